// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS-lite datapath.
// The master modport is the sequencer side; the slave modport is the datapath side.
interface multicycle_control_if #(
    parameter int OPW = 6
);
    logic [OPW-1:0] opcode;
    logic           mem_ready;
    logic           irwrite;
    logic           pcwrite;
    logic           branch_en;
    logic           iord;
    logic           memread;
    logic           memwrite;
    logic           memtoreg;
    logic           regdest;
    logic           regwrite;
    logic           alusrca;
    logic [1:0]     alusrcb;
    logic [1:0]     aluop;
    logic [1:0]     pcsrc;
    logic [2:0]     bj;
    logic           instr_done;
    logic           bus_err;
    logic [3:0]     state;

    modport master (
        input  opcode, mem_ready,
        output irwrite, pcwrite, branch_en, iord, memread, memwrite, memtoreg,
               regdest, regwrite, alusrca, alusrcb, aluop, pcsrc, bj,
               instr_done, bus_err, state
    );

    modport slave (
        output opcode, mem_ready,
        input  irwrite, pcwrite, branch_en, iord, memread, memwrite, memtoreg,
               regdest, regwrite, alusrca, alusrcb, aluop, pcsrc, bj,
               instr_done, bus_err, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the MIPS-lite datapath with a shared, variable
// latency memory port. Every memory access is bounded by MEM_TIMEOUT wait
// cycles; an expired access pulses bus_err and restarts at FETCH.
// Optional macro MC_ILLEGAL_TRAP_EN: an illegal opcode parks the FSM in TRAP
// (adds the trap output); otherwise an illegal opcode completes as a NOP.
//
// state       | meaning
// ------------+------------------------------------------------------------
// FETCH  (0)  | read instruction at PC, load IR and PC+4 on mem_ready
// DECODE (1)  | latch opcode, precompute branch target into ALUOut
// MEMADR (2)  | compute effective address rs + imm
// MEMRD  (3)  | load data read at ALUOut
// MEMWB  (4)  | write MDR into rt
// MEMWR  (5)  | store rt at ALUOut
// EXEC   (6)  | R-format / nori ALU operation
// ALUWB  (7)  | write ALUOut into rd (R-format) or rt (nori)
// BRANCH (8)  | compare and conditionally load PC with ALUOut
// JUMP   (9)  | load PC with jump target
// JSPAL  (10) | push return address to memory, then jump
// TRAP   (11) | illegal opcode trap, left only by reset
module multicycle_control #(
    parameter int OPW         = 6,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_control_if.master   bus
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    output logic                   trap
`endif
);

    localparam logic [OPW-1:0] OP_RFORMAT = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW      = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW      = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ     = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_BLTZ    = OPW'(6'b000001);
    localparam logic [OPW-1:0] OP_NORI    = OPW'(6'b001101);
    localparam logic [OPW-1:0] OP_BZ      = OPW'(6'b011000);
    localparam logic [OPW-1:0] OP_JSPAL   = OPW'(6'b010011);
    localparam logic [OPW-1:0] OP_J       = OPW'(6'b000010);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_JSPAL  = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [OPW-1:0] op_q;
    logic [7:0]     wait_q;
    logic           mem_state;
    logic           timeout;
    logic           stay;

    logic       irwrite, pcwrite, branch_en, iord, memread, memwrite;
    logic       memtoreg, regdest, regwrite, alusrca, instr_done, bus_err;
    logic       trap_d;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic [2:0] bj;

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                       (state_q == S_MEMWR) || (state_q == S_JSPAL);
    // A handshake in the timeout cycle still completes the access.
    assign timeout   = mem_state && !bus.mem_ready && (wait_q == 8'(MEM_TIMEOUT));
    assign stay      = mem_state && !bus.mem_ready && !timeout;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Wait counter: counts stalled cycles, cleared whenever a memory state is (re)entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     wait_q <= 8'd0;
        else if (stay) wait_q <= wait_q + 8'd1;
        else           wait_q <= 8'd0;
    end

    // Opcode latch: captured on the edge that leaves DECODE, stable for the rest of the instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   op_q <= '0;
        else if (state_q == S_DECODE) op_q <= bus.opcode;
    end

    // Next-state and control decode; all strobes are forced low while reset is held.
    always_comb begin
        state_d    = state_q;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch_en  = 1'b0;
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        memtoreg   = 1'b0;
        regdest    = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        pcsrc      = 2'b00;
        bj         = 3'b000;
        instr_done = 1'b0;
        bus_err    = 1'b0;
        trap_d     = 1'b0;
        case (state_q)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                if (bus.mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    bus_err = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW:             state_d = S_MEMADR;
                    OP_RFORMAT, OP_NORI:      state_d = S_EXEC;
                    OP_BEQ, OP_BLTZ, OP_BZ:   state_d = S_BRANCH;
                    OP_J:                     state_d = S_JUMP;
                    OP_JSPAL:                 state_d = S_JSPAL;
                    default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    bus_err = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                if (bus.mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (timeout) begin
                    bus_err = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alusrca = 1'b1;
                if (op_q == OP_RFORMAT) begin
                    alusrcb = 2'b00;
                    aluop   = 2'b10;
                end else begin
                    alusrcb = 2'b10;
                    aluop   = 2'b11;
                end
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite   = 1'b1;
                regdest    = (op_q == OP_RFORMAT);
                aluop      = (op_q == OP_RFORMAT) ? 2'b10 : 2'b11;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                aluop      = 2'b01;
                branch_en  = 1'b1;
                pcsrc      = 2'b01;
                instr_done = 1'b1;
                case (op_q)
                    OP_BLTZ: bj = 3'b101;
                    OP_BZ:   bj = 3'b001;
                    OP_BEQ:  bj = 3'b110;
                    default: bj = 3'b000;
                endcase
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pcwrite    = 1'b1;
                pcsrc      = 2'b10;
                bj         = 3'b010;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JSPAL: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                bj       = 3'b011;
                if (bus.mem_ready) begin
                    pcwrite    = 1'b1;
                    pcsrc      = 2'b10;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (timeout) begin
                    bus_err = 1'b1;
                    state_d = S_FETCH;
                end
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP: begin
                trap_d = 1'b1;
            end
`endif
            default: state_d = S_FETCH;
        endcase
        if (reset) begin
            irwrite    = 1'b0;
            pcwrite    = 1'b0;
            branch_en  = 1'b0;
            iord       = 1'b0;
            memread    = 1'b0;
            memwrite   = 1'b0;
            memtoreg   = 1'b0;
            regdest    = 1'b0;
            regwrite   = 1'b0;
            alusrca    = 1'b0;
            alusrcb    = 2'b00;
            aluop      = 2'b00;
            pcsrc      = 2'b00;
            bj         = 3'b000;
            instr_done = 1'b0;
            bus_err    = 1'b0;
            trap_d     = 1'b0;
        end
    end

    assign bus.irwrite    = irwrite;
    assign bus.pcwrite    = pcwrite;
    assign bus.branch_en  = branch_en;
    assign bus.iord       = iord;
    assign bus.memread    = memread;
    assign bus.memwrite   = memwrite;
    assign bus.memtoreg   = memtoreg;
    assign bus.regdest    = regdest;
    assign bus.regwrite   = regwrite;
    assign bus.alusrca    = alusrca;
    assign bus.alusrcb    = alusrcb;
    assign bus.aluop      = aluop;
    assign bus.pcsrc      = pcsrc;
    assign bus.bj         = bj;
    assign bus.instr_done = instr_done;
    assign bus.bus_err    = bus_err;
    assign bus.state      = state_q;
`ifdef MC_ILLEGAL_TRAP_EN
    assign trap           = trap_d;
`endif

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the MIPS-lite datapath. It replaces the single-cycle decoder when instruction and data memory share one port with variable latency.
- It decodes the same nine opcodes and drives the shared ALU, register file, IR, PC and memory port over several cycles per instruction.
- It waits on a memory-ready handshake and aborts any access that stalls too long.

Parameters:
- OPW, 6, opcode width.
- MEM_TIMEOUT, 15, maximum wait cycles per memory access before abort (1..255).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  OPW  IR[31:26], valid from DECODE onward.
- mem_ready  in  1  memory completes the current read/write this cycle.
- irwrite  out  1  load IR.
- pcwrite  out  1  unconditional PC load.
- branch_en  out  1  conditional PC load; datapath qualifies it with bj and flags.
- iord  out  1  0 = PC address, 1 = ALUOut address.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- memtoreg  out  1  register write data from MDR.
- regdest  out  1  rd (1) / rt (0).
- regwrite  out  1  register file write.
- alusrca  out  1  0 = PC, 1 = rs.
- alusrcb  out  2  00 rt, 01 const 4, 10 signext imm, 11 signext imm<<2.
- aluop  out  2  00 add, 01 sub/compare, 10 funct, 11 nor-immediate.
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- bj  out  3  branch/jump type: bltz 101, bz 001, jspal 011, j 010, beq 110, others 000.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- bus_err  out  1  one-cycle pulse on memory timeout.
- state  out  4  current state, for debug.

Behaviour:
- Opcodes:
  - rformat 000000, lw 100011, sw 101011, beq 000100, bltz 000001
  - nori 001101, bz 011000, jspal 010011, j 000010
- Reset: state = FETCH (0) and wait counter = 0. While reset is high, all outputs are 0 except state. Reset mid-instruction abandons it with no register or PC write.
- Outputs are Moore, decoded from state and latched opcode. Exception: the handshake-gated strobes listed per state.
- Opcode is latched at the DECODE edge; changes afterwards are ignored.
- States and transitions:
  - FETCH(0): memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. irwrite and pcwrite = mem_ready. On mem_ready -> DECODE.
  - DECODE(1): alusrca=0, alusrcb=11, aluop=00. lw/sw -> MEMADR; rformat/nori -> EXEC; beq/bltz/bz -> BRANCH; j -> JUMP; jspal -> JSPAL; illegal -> FETCH with instr_done=1.
  - MEMADR(2): alusrca=1, alusrcb=10, aluop=00. lw -> MEMRD; sw -> MEMWR.
  - MEMRD(3): memread=1, iord=1. On mem_ready -> MEMWB.
  - MEMWB(4): regwrite=1, memtoreg=1, regdest=0, instr_done=1 -> FETCH.
  - MEMWR(5): memwrite=1, iord=1. On mem_ready -> FETCH with instr_done=1.
  - EXEC(6): alusrca=1. rformat: alusrcb=00, aluop=10. nori: alusrcb=10, aluop=11. -> ALUWB.
  - ALUWB(7): regwrite=1, memtoreg=0, regdest=1 for rformat and 0 for nori, aluop held. instr_done=1 -> FETCH.
  - BRANCH(8): alusrca=1, alusrcb=00, aluop=01, branch_en=1, pcsrc=01, bj valid, instr_done=1 -> FETCH.
  - JUMP(9): pcwrite=1, pcsrc=10, bj=010, instr_done=1 -> FETCH.
  - JSPAL(10): memwrite=1, iord=1, bj=011. On mem_ready: pcwrite=1, pcsrc=10, instr_done=1 -> FETCH.
- bj is 000 in all other states.
- Wait counter (8 bit):
  - Cleared on entry to any memory state (0, 3, 5, 10).
  - Increments each cycle the FSM stays in a memory state with mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0: bus_err=1 for that cycle, no irwrite/pcwrite/regwrite, -> FETCH.
  - In FETCH a timeout leaves PC unchanged, so the same fetch retries.
- mem_ready in the same cycle as the timeout: the handshake wins and there is no bus_err.
- mem_ready outside memory states is ignored.
- Minimum cycles per instruction: lw 5, sw 4, R/nori 4, branch 3, j 3, jspal 3.

Optional Feature:
- MC_ILLEGAL_TRAP_EN defined:
  - Illegal opcode in DECODE -> TRAP(11).
  - TRAP holds all outputs 0 except instr_done=0 and trap=1 (extra 1-bit output port).
  - TRAP is left only by reset.
- Not defined: no trap port. An illegal opcode completes as a NOP: DECODE -> FETCH, instr_done pulse, no writes.

Test Plan:
- Reset asserted mid-MEMRD with mem_ready=0 -> state=0 asynchronously, all strobes 0. After release, FETCH memread=1 on first cycle.
- lw (100011), mem_ready=1 on every request -> states 0,1,2,3,4. regwrite=1 and memtoreg=1 in cycle 5, instr_done pulse, back to 0.
- sw (101011), mem_ready held low 3 cycles in MEMWR -> memwrite held 4 cycles with iord=1, then FETCH. No regwrite.
- beq (000100) -> BRANCH with branch_en=1, aluop=01, bj=110. j (000010) -> pcwrite=1, pcsrc=10, bj=010. Both take 3 cycles total.
- mem_ready never asserted in FETCH, MEM_TIMEOUT=15 -> bus_err pulse after 15 wait cycles. irwrite and pcwrite stay 0. FSM re-enters FETCH with counter cleared.
- Opcode 111111 -> without macro: DECODE->FETCH, instr_done=1, no writes. With MC_ILLEGAL_TRAP_EN: state=11, trap=1 until reset.
